// File: rtl/multi_seed_trace_filter.sv
// Multi-seed popcount trace filter: per-seed scoring, range matching, ANY/ALL combine,
// minimum-gap rate limiting and saturating statistics; keep_pkt gates trace FIFO writes.
module multi_seed_trace_filter #(
  parameter int DATA_W    = 512,
  parameter int NUM_SEEDS = 4,
  parameter int NUM_RNG   = 4,
  parameter int GAP_W     = 16,
  parameter int STAT_W    = 32,
  localparam int CW   = $clog2(DATA_W + 1),
  localparam int SA_W = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1,
  localparam int RA_W = (NUM_RNG > 1) ? $clog2(NUM_RNG) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    cfg_seed_we,
  input  logic [SA_W-1:0]         cfg_seed_addr,
  input  logic [DATA_W-1:0]       cfg_seed,
  input  logic [DATA_W-1:0]       cfg_mask,
  input  logic                    cfg_rng_we,
  input  logic [RA_W-1:0]         cfg_rng_addr,
  input  logic [CW-1:0]           cfg_lower,
  input  logic [CW-1:0]           cfg_upper,
  input  logic                    cfg_rng_en,
  input  logic                    cfg_mode_all,
  input  logic [GAP_W-1:0]        cfg_min_gap,
  input  logic                    stats_clr,
  output logic                    out_valid,
  output logic                    keep_pkt,
  output logic                    drop_pkt,
  output logic [NUM_SEEDS*CW-1:0] scores,
  output logic [STAT_W-1:0]       kept_count,
  output logic [STAT_W-1:0]       dropped_count,
  output logic [STAT_W-1:0]       rate_drop_count
);

  function automatic logic [CW-1:0] popcount(input logic [DATA_W-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int k = 0; k < DATA_W; k++) begin
      c = c + {{(CW-1){1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Clear wins over increment; increment holds at all-ones.
  function automatic logic [STAT_W-1:0] sat_next(input logic [STAT_W-1:0] cnt,
                                                 input logic inc, input logic clr);
    logic [STAT_W-1:0] n;
    if (clr) begin
      n = {STAT_W{1'b0}};
    end else if (inc && (cnt != {STAT_W{1'b1}})) begin
      n = cnt + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      n = cnt;
    end
    return n;
  endfunction

  logic [DATA_W-1:0]  seed_r   [NUM_SEEDS];
  logic [DATA_W-1:0]  mask_r   [NUM_SEEDS];
  logic [CW-1:0]      lower_r  [NUM_SEEDS][NUM_RNG];
  logic [CW-1:0]      upper_r  [NUM_SEEDS][NUM_RNG];
  logic [NUM_RNG-1:0] rng_en_r [NUM_SEEDS];

  logic               v1_r, e1_r, v2_r, e2_r;
  logic [DATA_W-1:0]  x1_r     [NUM_SEEDS];
  logic [CW-1:0]      score2_r [NUM_SEEDS];
  logic [GAP_W-1:0]   gap_cnt_r;

  logic [NUM_SEEDS-1:0] hit_s, active_s;
  logic match_s, cand_s, keep_s, drop_s, rate_s;

  // Configuration storage; seed and range writes may coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEEDS; i++) begin
        seed_r[i]   <= {DATA_W{1'b0}};
        mask_r[i]   <= {DATA_W{1'b0}};
        rng_en_r[i] <= {NUM_RNG{1'b0}};
        for (int j = 0; j < NUM_RNG; j++) begin
          lower_r[i][j] <= {CW{1'b0}};
          upper_r[i][j] <= {CW{1'b0}};
        end
      end
    end else begin
      for (int i = 0; i < NUM_SEEDS; i++) begin
        if (cfg_seed_we && (cfg_seed_addr == SA_W'(i))) begin
          seed_r[i] <= cfg_seed;
          mask_r[i] <= cfg_mask;
        end
        for (int j = 0; j < NUM_RNG; j++) begin
          if (cfg_rng_we && (cfg_seed_addr == SA_W'(i)) && (cfg_rng_addr == RA_W'(j))) begin
            lower_r[i][j]  <= cfg_lower;
            upper_r[i][j]  <= cfg_upper;
            rng_en_r[i][j] <= cfg_rng_en;
          end
        end
      end
    end
  end

  // Stages 1 and 2: masked agreement vector, then its popcount.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      e1_r <= 1'b0;
      v2_r <= 1'b0;
      e2_r <= 1'b0;
      for (int i = 0; i < NUM_SEEDS; i++) begin
        x1_r[i]     <= {DATA_W{1'b0}};
        score2_r[i] <= {CW{1'b0}};
      end
    end else begin
      v1_r <= in_valid;
      e1_r <= en;
      v2_r <= v1_r;
      e2_r <= e1_r;
      for (int i = 0; i < NUM_SEEDS; i++) begin
        x1_r[i]     <= ~(data_in ^ seed_r[i]) & mask_r[i];
        score2_r[i] <= popcount(x1_r[i]);
      end
    end
  end

  // Stage 3: range matching against the ranges current this cycle, then seed combine.
  always_comb begin
    hit_s    = {NUM_SEEDS{1'b0}};
    active_s = {NUM_SEEDS{1'b0}};
    for (int i = 0; i < NUM_SEEDS; i++) begin
      active_s[i] = |rng_en_r[i];
      for (int j = 0; j < NUM_RNG; j++) begin
        if (rng_en_r[i][j] && (score2_r[i] >= lower_r[i][j]) && (score2_r[i] <= upper_r[i][j])) begin
          hit_s[i] = 1'b1;
        end else begin
          hit_s[i] = hit_s[i];
        end
      end
    end
    if (cfg_mode_all) begin
      match_s = (|active_s) && (&(hit_s | ~active_s));
    end else begin
      match_s = |hit_s;
    end
    cand_s = v2_r && e2_r && match_s;
    keep_s = cand_s && (gap_cnt_r == {GAP_W{1'b0}});
    drop_s = v2_r && !keep_s;
    rate_s = cand_s && (gap_cnt_r != {GAP_W{1'b0}});
  end

  // Registered decision, scores, gap limiter and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      keep_pkt        <= 1'b0;
      drop_pkt        <= 1'b0;
      scores          <= {(NUM_SEEDS*CW){1'b0}};
      gap_cnt_r       <= {GAP_W{1'b0}};
      kept_count      <= {STAT_W{1'b0}};
      dropped_count   <= {STAT_W{1'b0}};
      rate_drop_count <= {STAT_W{1'b0}};
    end else begin
      out_valid <= v2_r;
      keep_pkt  <= keep_s;
      drop_pkt  <= drop_s;
      for (int i = 0; i < NUM_SEEDS; i++) begin
        scores[i*CW +: CW] <= score2_r[i];
      end
      // A running gap is never shortened by a smaller cfg_min_gap.
      if (keep_s && (cfg_min_gap != {GAP_W{1'b0}})) begin
        gap_cnt_r <= cfg_min_gap - {{(GAP_W-1){1'b0}}, 1'b1};
      end else if (gap_cnt_r != {GAP_W{1'b0}}) begin
        gap_cnt_r <= gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
      end
      kept_count      <= sat_next(kept_count, keep_s, stats_clr);
      dropped_count   <= sat_next(dropped_count, drop_s, stats_clr);
      rate_drop_count <= sat_next(rate_drop_count, rate_s, stats_clr);
    end
  end

endmodule
